router_ctrl_fsm: RTL

ROUTER_CTRL_FSM -- requirements
Module: router_ctrl_fsm

---
 rtl/router_ctrl_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm: packet router control FSM steering source bytes into one of three output FIFOs.
// Optional feature: define ROUTER_CTRL_SOFT_RESET_EN to add the per-channel soft-reset read timeout.
module router_ctrl_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

    state_t     r_state;
    logic [1:0] r_addr;
    logic [1:0] w_hdr;
    logic [3:0] w_full_x;
    logic [3:0] w_empty_x;
    logic [3:0] w_sr_x;
    logic       w_full;
    logic       w_empty;
    logic       w_hdr_empty;
    logic       w_sr;
    logic       w_wr;
    logic       w_unused;

    // padding FIFO status to 4 bits lets a 2-bit address index it without range issues
    assign w_hdr       = data_in[1:0];
    assign w_full_x    = {1'b0, fifo_full};
    assign w_empty_x   = {1'b0, fifo_empty};
    assign w_sr_x      = {1'b0, soft_reset};
    assign w_full      = w_full_x[r_addr];
    assign w_empty     = w_empty_x[r_addr];
    assign w_hdr_empty = w_empty_x[w_hdr];
    assign vld_out     = ~fifo_empty;
    assign w_unused    = ^{data_in[7:2], read_enb};

`ifdef ROUTER_CTRL_SOFT_RESET_EN
    logic [4:0] r_cnt [3];
    logic [2:0] r_soft_reset;

    // per-channel timeout: a valid FIFO left unread for 30 cycles gets a one-cycle soft reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) r_cnt[i] <= 5'd0;
            r_soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (vld_out[i] && !read_enb[i]) begin
                    r_cnt[i]        <= (r_cnt[i] == 5'd29) ? 5'd0 : r_cnt[i] + 5'd1;
                    r_soft_reset[i] <= (r_cnt[i] == 5'd29);
                end else begin
                    r_cnt[i]        <= 5'd0;
                    r_soft_reset[i] <= 1'b0;
                end
            end
        end
    end

    assign soft_reset = r_soft_reset;
    assign w_sr       = w_sr_x[r_addr] && (r_state != DECODE_ADDRESS);
`else
    assign soft_reset = 3'b000;
    assign w_sr       = w_sr_x[r_addr] & 1'b0;
`endif

    // state register and latched destination address
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else if (w_sr) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (pkt_valid && w_hdr != 2'd3) begin
                        r_addr  <= w_hdr;
                        r_state <= w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY:    r_state <= w_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:    r_state <= LOAD_DATA;
                LOAD_DATA:          r_state <= w_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
                FIFO_FULL_STATE:    r_state <= w_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:    r_state <= pkt_valid ? LOAD_DATA : LOAD_PARITY;
                LOAD_PARITY:        r_state <= w_full ? LOAD_PARITY : CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: r_state <= DECODE_ADDRESS;
                default:            r_state <= DECODE_ADDRESS;
            endcase
        end
    end

    // flags, busy and the one-hot write strobe decoded from the registered state
    always_comb begin
        detect_add  = (r_state == DECODE_ADDRESS);
        lfd_state   = (r_state == LOAD_FIRST_DATA);
        ld_state    = (r_state == LOAD_DATA);
        laf_state   = (r_state == LOAD_AFTER_FULL);
        full_state  = (r_state == FIFO_FULL_STATE);
        rst_int_reg = (r_state == CHECK_PARITY_ERROR);
        busy        = !(detect_add || ld_state);
        w_wr        = (lfd_state || laf_state || ((ld_state || r_state == LOAD_PARITY) && !w_full)) && !w_sr;
        write_enb   = w_wr ? (3'b001 << r_addr) : 3'b000;
    end
endmodule
